// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: single-outstanding load/store initiator with alignment, range and funct3 checks
module lsu_mem_ctrl #(
  parameter int MEM_DEPTH = 10,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic            flush,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            exc_valid,
  output logic [3:0]      exc_cause,
  output logic [XLEN-1:0] exc_tval,
  output logic [XLEN-1:0] mem_adr,
  output logic [1:0]      mem_op,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_wdin,
  input  logic [XLEN-1:0] mem_rdo
);
  localparam logic [1:0] W_B = 2'd0, W_H = 2'd1, W_W = 2'd2;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP, EXC} state_t;
  state_t          state, state_n;
  logic [XLEN-1:0] addr_q, wdata_q, load_data;
  logic [2:0]      f3_q;
  logic            we_q, accept, mis, oob, bad_f3;
  logic [3:0]      cause_q, cause_d;
  logic [1:0]      sz;
  assign sz        = req_funct3[1:0];
  assign mis       = (sz == 2'd1 & req_addr[0]) | (sz == 2'd2 & req_addr[1:0] != 2'b00);
  assign oob       = |req_addr[XLEN-1:MEM_DEPTH];
  assign bad_f3    = req_we ? (req_funct3 >= 3'd3) : (sz == 2'd3 | req_funct3[2:1] == 2'b11);
  assign cause_d   = mis ? (req_we ? 4'd6 : 4'd4) : (oob | bad_f3) ? (req_we ? 4'd7 : 4'd5) : 4'd0;
  assign req_ready = (state == IDLE) & ~flush;
  assign accept    = req_valid & req_ready;
  assign mem_adr   = addr_q;
  assign mem_wdin  = wdata_q;
  assign mem_op    = f3_q[1:0] == 2'd0 ? W_B : f3_q[1:0] == 2'd1 ? W_H : W_W;
  assign exc_cause = cause_q;
  assign exc_tval  = addr_q;
  // memory already returns the addressed byte/halfword in the low lanes
  assign load_data = f3_q == 3'd0 ? {{(XLEN-8){mem_rdo[7]}}, mem_rdo[7:0]} :
                     f3_q == 3'd4 ? {{(XLEN-8){1'b0}}, mem_rdo[7:0]} :
                     f3_q == 3'd1 ? {{(XLEN-16){mem_rdo[15]}}, mem_rdo[15:0]} :
                     f3_q == 3'd5 ? {{(XLEN-16){1'b0}}, mem_rdo[15:0]} : mem_rdo;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      cause_q <= '0;
    end else if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      f3_q    <= req_funct3;
      we_q    <= req_we;
      cause_q <= cause_d;
    end
  end
  always_comb begin
    state_n   = state;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    exc_valid = 1'b0;
    mem_we    = 1'b0;
    case (state)
      IDLE:  state_n = accept ? (|cause_d ? EXC : ISSUE) : IDLE;
      ISSUE: begin
        mem_we  = we_q & ~flush;
        state_n = flush ? IDLE : RESP;
      end
      RESP: begin
        rsp_valid = ~flush;
        rsp_rdata = we_q ? '0 : load_data;
        state_n   = IDLE;
      end
      EXC: begin
        exc_valid = ~flush;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: scoreboard bench for lsu_mem_ctrl with a byte-addressed dram model
module tb_lsu_mem_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, clr = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, flush = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, exc_valid, mem_we;
  logic [31:0] rsp_rdata, exc_tval, mem_adr, mem_wdin, mem_rdo;
  logic [3:0]  exc_cause;
  logic [1:0]  mem_op;
  logic [7:0]  dmem [0:1023];
  logic [9:0]  ma;
  typedef struct packed {logic exc; logic [3:0] cause; logic [31:0] val;} exp_t;
  exp_t q[$];
  exp_t m;
  int pass_cnt = 0, total_cnt = 0, we_cnt = 0, cyc = 0, acc_cyc = 0;

  lsu_mem_ctrl #(.MEM_DEPTH(10), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_tval(exc_tval), .mem_adr(mem_adr), .mem_op(mem_op), .mem_we(mem_we),
    .mem_wdin(mem_wdin), .mem_rdo(mem_rdo));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // dram: op 0/1/2 = byte/half/word, read returns 4 bytes starting at the address
  assign ma = mem_adr[9:0];
  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 1024; i++) dmem[i] <= 8'h00;
    else if (mem_we) begin
      dmem[ma] <= mem_wdin[7:0];
      if (mem_op != 2'd0) dmem[ma+10'd1] <= mem_wdin[15:8];
      if (mem_op == 2'd2) begin
        dmem[ma+10'd2] <= mem_wdin[23:16];
        dmem[ma+10'd3] <= mem_wdin[31:24];
      end
    end
    mem_rdo <= {dmem[ma+10'd3], dmem[ma+10'd2], dmem[ma+10'd1], dmem[ma]};
  end

  function automatic logic [31:0] mword(input logic [9:0] a);
    return {dmem[a+10'd3], dmem[a+10'd2], dmem[a+10'd1], dmem[a]};
  endfunction

  always @(negedge clk) if (mem_we) we_cnt++;

  always @(negedge clk) begin
    if (rst_n && (rsp_valid || exc_valid)) begin
      total_cnt++;
      if (q.size() == 0)
        $display("FAIL unexpected_pulse rsp_valid=%b exc_valid=%b rdata=%h cause=%0d", rsp_valid, exc_valid, rsp_rdata, exc_cause);
      else begin
        m = q.pop_front();
        if ({rsp_valid & exc_valid, exc_valid, exc_valid ? exc_cause : 4'd0, exc_valid ? exc_tval : rsp_rdata} !== {1'b0, m})
          $display("FAIL scoreboard got exc=%b cause=%0d val=%h both=%b, want exc=%b cause=%0d val=%h",
                   exc_valid, exc_cause, exc_valid ? exc_tval : rsp_rdata, rsp_valid & exc_valid, m.exc, m.cause, m.val);
        else pass_cnt++;
      end
    end
  end

  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      input bit push, input logic ex, input logic [3:0] cause, input logic [31:0] val);
    exp_t e;
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total_cnt++;
      $display("FAIL send_timeout addr=%h req_ready stayed 0", a);
    end
    if (push) begin
      e.exc = ex; e.cause = cause; e.val = val;
      q.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({rsp_valid, exc_valid, mem_we, mem_adr, mem_wdin, mem_op, exc_cause, exc_tval, rsp_rdata} !== '0)
      $display("FAIL reset_outputs got rsp=%b exc=%b we=%b adr=%h wdin=%h op=%0d cause=%0d tval=%h rdata=%h want all 0",
               rsp_valid, exc_valid, mem_we, mem_adr, mem_wdin, mem_op, exc_cause, exc_tval, rsp_rdata);
    else pass_cnt++;
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready);
    else pass_cnt++;
    clr = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_word_roundtrip;
    int w0;
    w0 = we_cnt;
    send(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 4'd0, 32'h0);
    @(negedge clk);
    total_cnt++;
    if ({mem_we, req_ready, mem_adr, mem_op, mem_wdin} !== {1'b1, 1'b0, 32'h10, 2'd2, 32'hDEADBEEF})
      $display("FAIL sw_issue got we=%b ready=%b adr=%h op=%0d wdin=%h want 1 0 10 2 deadbeef", mem_we, req_ready, mem_adr, mem_op, mem_wdin);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({mem_we, req_ready} !== 2'b00) $display("FAIL sw_resp got we=%b ready=%b want 0 0", mem_we, req_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (mword(10'h10) !== 32'hDEADBEEF || we_cnt - w0 !== 1)
      $display("FAIL sw_mem got word=%h we_cycles=%0d want deadbeef 1", mword(10'h10), we_cnt - w0);
    else pass_cnt++;
    send(1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 1'b0, 4'd0, 32'hDEADBEEF);
    @(negedge clk);
    total_cnt++;
    if ({rsp_valid, req_ready} !== 2'b00) $display("FAIL lw_t1 got rsp=%b ready=%b want 0 0", rsp_valid, req_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({rsp_valid, req_ready} !== 2'b10) $display("FAIL lw_latency got rsp=%b ready=%b want 1 0", rsp_valid, req_ready);
    else pass_cnt++;
  endtask

  task automatic test_subword;
    send(1'b1, 3'd2, 32'h20, 32'h80F08182, 1'b1, 1'b0, 4'd0, 32'h0);
    send(1'b0, 3'd0, 32'h20, 32'h0, 1'b1, 1'b0, 4'd0, 32'hFFFFFF82);
    send(1'b0, 3'd4, 32'h20, 32'h0, 1'b1, 1'b0, 4'd0, 32'h00000082);
    send(1'b0, 3'd1, 32'h22, 32'h0, 1'b1, 1'b0, 4'd0, 32'hFFFF80F0);
    send(1'b0, 3'd5, 32'h22, 32'h0, 1'b1, 1'b0, 4'd0, 32'h000080F0);
    send(1'b1, 3'd0, 32'h21, 32'h12345655, 1'b1, 1'b0, 4'd0, 32'h0);
    send(1'b0, 3'd2, 32'h20, 32'h0, 1'b1, 1'b0, 4'd0, 32'h80F05582);
    repeat (2) @(negedge clk);
    total_cnt++;
    if (mword(10'h24) !== 32'h0) $display("FAIL sb_neighbour got %h want 0", mword(10'h24));
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int c0;
    send(1'b1, 3'd2, 32'h3FC, 32'hCAFEF00D, 1'b1, 1'b0, 4'd0, 32'h0);
    c0 = acc_cyc;
    send(1'b0, 3'd2, 32'h3FC, 32'h0, 1'b1, 1'b0, 4'd0, 32'hCAFEF00D);
    total_cnt++;
    if (acc_cyc - c0 !== 3) $display("FAIL throughput got %0d cycles want 3", acc_cyc - c0);
    else pass_cnt++;
  endtask

  task automatic test_misalign;
    int w0;
    w0 = we_cnt;
    send(1'b0, 3'd2, 32'h102, 32'h0, 1'b1, 1'b1, 4'd4, 32'h102);
    @(negedge clk);
    total_cnt++;
    if ({exc_valid, rsp_valid, mem_we} !== 3'b100) $display("FAIL lw_mis_pulse got exc=%b rsp=%b we=%b want 1 0 0", exc_valid, rsp_valid, mem_we);
    else pass_cnt++;
    send(1'b1, 3'd1, 32'h3FF, 32'hFFFF, 1'b1, 1'b1, 4'd6, 32'h3FF);
    send(1'b0, 3'd2, 32'h3FE, 32'h0, 1'b1, 1'b1, 4'd4, 32'h3FE);
    send(1'b1, 3'd5, 32'h401, 32'h0, 1'b1, 1'b1, 4'd6, 32'h401);
    repeat (2) @(negedge clk);
    total_cnt++;
    if (we_cnt !== w0 || mword(10'h3FC) !== 32'hCAFEF00D)
      $display("FAIL mis_no_write got we_cycles=%0d word=%h want 0 cafef00d", we_cnt - w0, mword(10'h3FC));
    else pass_cnt++;
  endtask

  task automatic test_access_fault;
    int w0;
    w0 = we_cnt;
    send(1'b0, 3'd2, 32'h400, 32'h0, 1'b1, 1'b1, 4'd5, 32'h400);
    send(1'b1, 3'd3, 32'h0, 32'h55AA55AA, 1'b1, 1'b1, 4'd7, 32'h0);
    send(1'b1, 3'd0, 32'h400, 32'h11, 1'b1, 1'b1, 4'd7, 32'h400);
    send(1'b0, 3'd6, 32'h8, 32'h0, 1'b1, 1'b1, 4'd5, 32'h8);
    send(1'b0, 3'd0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, 4'd5, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    total_cnt++;
    if (we_cnt !== w0 || mword(10'h0) !== 32'h0) $display("FAIL acc_no_write got we_cycles=%0d word0=%h want 0 0", we_cnt - w0, mword(10'h0));
    else pass_cnt++;
  endtask

  task automatic test_flush;
    send(1'b1, 3'd2, 32'h40, 32'hA5A5A5A5, 1'b1, 1'b0, 4'd0, 32'h0);
    send(1'b1, 3'd2, 32'h40, 32'h11111111, 1'b0, 1'b0, 4'd0, 32'h0);
    flush = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({mem_we, rsp_valid} !== 2'b00) $display("FAIL flush_issue got we=%b rsp=%b want 0 0", mem_we, rsp_valid);
    else pass_cnt++;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL flush_issue_idle got ready=%b want 1", req_ready);
    else pass_cnt++;
    send(1'b0, 3'd2, 32'h40, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0);
    @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (rsp_valid !== 1'b0) $display("FAIL flush_resp got rsp=%b want 0", rsp_valid);
    else pass_cnt++;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL flush_resp_idle got ready=%b want 1", req_ready);
    else pass_cnt++;
    flush = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = 32'h0BAD0BAD;
    #1;
    total_cnt++;
    if (req_ready !== 1'b0) $display("FAIL flush_idle_ready got %b want 0", req_ready);
    else pass_cnt++;
    @(posedge clk);
    #1 req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({mem_we, req_ready} !== 2'b01) $display("FAIL flush_idle_block got we=%b ready=%b want 0 1", mem_we, req_ready);
    else pass_cnt++;
    send(1'b0, 3'd2, 32'h40, 32'h0, 1'b1, 1'b0, 4'd0, 32'hA5A5A5A5);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset;
    send(1'b1, 3'd2, 32'h50, 32'h77777777, 1'b0, 1'b0, 4'd0, 32'h0);
    #1;
    total_cnt++;
    if (mem_we !== 1'b1) $display("FAIL rst_pre_we got %b want 1", mem_we);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({rsp_valid, exc_valid, mem_we, mem_adr, mem_wdin, mem_op, exc_cause, exc_tval, rsp_rdata} !== '0)
      $display("FAIL rst_async got we=%b adr=%h wdin=%h op=%0d cause=%0d tval=%h want all 0", mem_we, mem_adr, mem_wdin, mem_op, exc_cause, exc_tval);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (req_ready !== 1'b1 || mword(10'h50) !== 32'h0) $display("FAIL rst_release got ready=%b word=%h want 1 0", req_ready, mword(10'h50));
    else pass_cnt++;
    send(1'b0, 3'd2, 32'h50, 32'h0, 1'b1, 1'b0, 4'd0, 32'h0);
  endtask

  initial begin
    test_reset;
    test_word_roundtrip;
    test_subword;
    test_back_to_back;
    test_misalign;
    test_access_fault;
    test_flush;
    test_async_reset;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    total_cnt++;
    if (q.size() != 0) $display("FAIL drain got %0d pending responses want 0", q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator that sits between the MEM pipeline stage and the byte-addressed data memory `dram`.
- Accepts one load/store request at a time and checks alignment, range and funct3.
- Drives the memory interface (adr/op/we/wdin), waits for the memory's one-cycle registered read, then returns formatted load data with sign/zero extension.
- Raises precise exceptions (cause plus faulting address) toward the trap unit and honours pipeline flush.

Parameters:
- MEM_DEPTH, 10: address bits implemented by the data memory. Addresses >= 2**MEM_DEPTH fault.
- XLEN, 32: data and address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  MEM stage presents a load/store
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2
- req_addr  in  XLEN  effective byte address
- req_wdata  in  XLEN  store data, right-aligned
- flush  in  1  synchronous pipeline flush (trap/redirect)
- rsp_valid  out  1  one-cycle pulse: access completed (load data valid, or store acknowledged)
- rsp_rdata  out  XLEN  formatted load data; 0 for stores
- exc_valid  out  1  one-cycle pulse: request faulted
- exc_cause  out  4  4 = load misaligned, 5 = load access fault, 6 = store misaligned, 7 = store access fault
- exc_tval  out  XLEN  faulting address
- mem_adr  out  XLEN  to dram adr
- mem_op  out  2  to dram op, encoded with `W_B`/`W_H`/`W_W` from defines.v
- mem_we  out  1  to dram we
- mem_wdin  out  XLEN  to dram wdin
- mem_rdo  in  XLEN  from dram rdo, registered one cycle after the address

Behaviour:
- States: IDLE, ISSUE, RESP, EXC.
- Reset (asynchronous, rst_n=0):
  - state = IDLE; latched addr, wdata, funct3 and we = 0.
  - rsp_valid = 0, exc_valid = 0, mem_we = 0, mem_adr = 0, mem_wdin = 0, mem_op = 0.
  - exc_cause = 0, exc_tval = 0, rsp_rdata = 0.
  - Reset mid-access abandons the access; no write occurs after rst_n falls.
- req_ready = (state == IDLE) & ~flush.
- Acceptance happens on a clock edge with req_valid & req_ready. At that edge the block latches addr, wdata, funct3 and we, then evaluates checks in priority order:
  1. Misaligned: funct3[1:0] = 1 with addr[0] != 0, or funct3[1:0] = 2 with addr[1:0] != 0. Result: cause 4 (load) or 6 (store).
  2. Access fault: addr >= 2**MEM_DEPTH, or invalid funct3 (load: 3, 6, 7; store: >= 3). Result: cause 5 (load) or 7 (store).
  3. Otherwise the request is valid.
- Next state after acceptance: EXC if any check fails, else ISSUE.
- ISSUE (1 cycle):
  - mem_adr = latched addr; mem_op = size from funct3[1:0]; mem_wdin = latched wdata, unshifted.
  - mem_we = latched we & ~flush.
  - The dram samples at the edge ending ISSUE. Next state is RESP, or IDLE if flush.
- RESP (1 cycle): rsp_valid = ~flush.
  - Loads: rsp_rdata is derived combinationally from mem_rdo. The addressed byte is always mem_rdo[7:0] and the halfword is always mem_rdo[15:0].
    - LB: sign-extend [7:0]; LBU: zero-extend [7:0].
    - LH: sign-extend [15:0]; LHU: zero-extend [15:0].
    - LW: full word.
  - Stores: rsp_rdata = 0. Next state is IDLE.
- EXC (1 cycle):
  - exc_valid = ~flush; exc_cause and exc_tval are held from the latch.
  - mem_we = 0 and the memory is never accessed. Next state is IDLE.
- mem_we is 0 in every state except ISSUE. mem_adr, mem_op and mem_wdin hold their last latched values outside ISSUE.
- Latency: acceptance edge T0, memory access edge T1, rsp_valid during T1..T2. Throughput is one request per 3 cycles.
- flush in IDLE blocks acceptance. flush in ISSUE cancels the store write and suppresses the response. flush in RESP/EXC suppresses the pulse.
- rsp_valid and exc_valid are never both 1.
- Boundaries:
  - LW at 0x3FC is legal (top word).
  - LW at 0x3FE is misaligned (cause 4). This prevents the dram index wrap.
  - SH at 0x3FF is misaligned (cause 6), not an access fault.
  - Address 0x400 faults with cause 5 or 7.

Test Plan:
- Word round-trip: SW addr 0x10, wdata 0xDEADBEEF, then LW 0x10 → mem_we high for exactly 1 cycle; load rsp_valid 2 cycles after acceptance with rsp_rdata = 0xDEADBEEF; req_ready low during ISSUE/RESP.
- Sub-word extension: memory word at 0x20 = 0x80F08182.
  - LB 0x20 → 0xFFFFFF82; LBU 0x20 → 0x00000082.
  - LH 0x22 → 0xFFFF80F0; LHU 0x22 → 0x000080F0.
  - SB 0x21 with wdata 0x12345655 changes only byte 0x21 to 0x55.
- Misalignment: LW 0x102 → exc_valid, cause 4, tval 0x102, rsp_valid 0. SH 0x3FF → cause 6, tval 0x3FF, mem_we never asserted.
- Access fault: LW 0x400 → cause 5, tval 0x400. SW 0x0 with funct3 = 3 → cause 7, memory unchanged.
- Flush: SW 0x40 with flush high during ISSUE → mem_we stays 0, no rsp_valid, later LW 0x40 returns the old value. Flush during RESP → rsp_valid suppressed, state IDLE next cycle.
- Async reset: rst_n low mid-ISSUE of SW → mem_we drops immediately, all outputs 0, req_ready = 1 after release, memory unchanged.
